// File: rtl/fifo_packet_reader_pkg.sv
// Shared types and constants for the FIFO packet reader slice.
package fifo_pkt_pkg;

  localparam int PKT_DATA_W = 8;
  localparam int PKT_CNT_W  = 16;
  localparam int BUF_DEPTH  = 2;

  // Issue-side FSM: fetch header, wait for it to return, fetch payload.
  typedef enum logic [1:0] {
    ISS_HDR  = 2'd0,
    ISS_WAIT = 2'd1,
    ISS_PAY  = 2'd2
  } iss_state_e;

  // One stream beat as held in the output buffer.
  typedef struct packed {
    logic                  last;
    logic [PKT_DATA_W-1:0] data;
  } pkt_beat_t;

endpackage

// File: rtl/fifo_packet_reader_if.sv
// FIFO read port plus outgoing byte stream and status of the packet reader.
interface fifo_packet_reader_if
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int CNT_W  = PKT_CNT_W
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_ren;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              busy;

  // Reader side: consumes the FIFO, produces the stream.
  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, out_data, out_valid, out_last, pkt_cnt, drop_cnt, busy
  );

  // Environment side: FIFO and downstream consumer.
  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, out_data, out_valid, out_last, pkt_cnt, drop_cnt, busy
  );

endinterface

// File: rtl/fifo_packet_reader_buf.sv
// Two-entry {data,last} skid buffer feeding the output stream.
// Outputs come straight from storage, so the stream is registered.
module pkt_out_buf
  import fifo_pkt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  pkt_beat_t push_beat,
  output logic      valid,
  input  logic      ready,
  output pkt_beat_t beat,
  output logic [1:0] occ
);

  pkt_beat_t  mem_r [BUF_DEPTH];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] occ_r;
  logic       pop_s;

  assign valid = (occ_r != 2'd0);
  assign pop_s = valid & ready;
  assign beat  = mem_r[rd_ptr_r];
  assign occ   = occ_r;

  // Storage, pointers and occupancy; a push while full is only ever paired
  // with a pop, and then it lands in the slot being vacated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_beat;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/fifo_packet_reader.sv
// Drains length-prefixed packets from a registered-read FIFO and re-emits the
// payload as a valid/ready byte stream with a last flag. Reads are issued only
// when the output buffer is guaranteed a slot for the returning byte.
module fifo_packet_reader
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int CNT_W  = PKT_CNT_W
)
(
  input  logic                 clk,
  input  logic                 rst,
  fifo_packet_reader_if.master bus
);

  localparam logic [DATA_W-1:0] REM_ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] LEN_ZERO = DATA_W'(0);

  iss_state_e        state_r;
  iss_state_e        state_nxt_s;
  logic [DATA_W-1:0] rem_r;
  logic              infl_pay_r;
  logic              infl_last_r;
  logic [CNT_W-1:0]  pkt_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  logic              ren_s;
  logic              pop_s;
  logic [2:0]        credit_s;
  logic              can_read_s;
  logic              buf_valid_s;
  pkt_beat_t         buf_beat_s;
  pkt_beat_t         push_beat_s;
  logic [1:0]        occ_s;

  // Slots committed to the buffer: held beats plus a payload read in flight,
  // less the beat leaving this cycle.
  assign pop_s      = buf_valid_s & bus.out_ready;
  assign credit_s   = {1'b0, occ_s} + {2'b00, infl_pay_r} - {2'b00, pop_s};
  assign can_read_s = ~bus.fifo_empty & (credit_s < 3'd2);

  assign push_beat_s.last = infl_last_r;
  assign push_beat_s.data = bus.fifo_rdata;

  pkt_out_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_pay_r),
    .push_beat (push_beat_s),
    .valid     (buf_valid_s),
    .ready     (bus.out_ready),
    .beat      (buf_beat_s),
    .occ       (occ_s)
  );

  // Issue FSM next state and FIFO read request.
  always_comb begin
    state_nxt_s = state_r;
    ren_s       = 1'b0;
    case (state_r)
      ISS_HDR: begin
        if (can_read_s) begin
          ren_s       = 1'b1;
          state_nxt_s = ISS_WAIT;
        end else begin
          state_nxt_s = ISS_HDR;
        end
      end
      ISS_WAIT: begin
        if (bus.fifo_rdata == LEN_ZERO) begin
          state_nxt_s = ISS_HDR;
        end else begin
          state_nxt_s = ISS_PAY;
        end
      end
      ISS_PAY: begin
        if (can_read_s) begin
          ren_s = 1'b1;
          if (rem_r == REM_ONE) begin
            state_nxt_s = ISS_HDR;
          end else begin
            state_nxt_s = ISS_PAY;
          end
        end else begin
          state_nxt_s = ISS_PAY;
        end
      end
      default: begin
        state_nxt_s = ISS_HDR;
      end
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ISS_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Remaining-payload count and the tag of the payload read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r       <= LEN_ZERO;
      infl_pay_r  <= 1'b0;
      infl_last_r <= 1'b0;
    end else begin
      if ((state_r == ISS_WAIT) && (bus.fifo_rdata != LEN_ZERO)) begin
        rem_r <= bus.fifo_rdata;
      end else if ((state_r == ISS_PAY) && ren_s) begin
        rem_r <= rem_r - REM_ONE;
      end
      infl_pay_r  <= ren_s & (state_r == ISS_PAY);
      infl_last_r <= (rem_r == REM_ONE);
    end
  end

  // Packet and dropped-header counters; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pop_s && buf_beat_s.last) begin
        pkt_cnt_r <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((state_r == ISS_WAIT) && (bus.fifo_rdata == LEN_ZERO)) begin
        drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.fifo_ren  = ren_s & ~rst;
  assign bus.out_valid = buf_valid_s;
  assign bus.out_data  = buf_beat_s.data;
  assign bus.out_last  = buf_beat_s.last;
  assign bus.pkt_cnt   = pkt_cnt_r;
  assign bus.drop_cnt  = drop_cnt_r;
  assign bus.busy      = (state_r != ISS_HDR) | infl_pay_r | (occ_s != 2'd0);

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench for fifo_packet_reader. The bench owns a registered-read FIFO
// model and a packet-level reference: every byte written is parsed into the
// expected beat list, and each accepted beat is checked against it.
module tb_fifo_packet_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_packet_reader_if #(.DATA_W(8), .CNT_W(16)) bus();

  fifo_packet_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int         p_rem    = 0;
  int         exp_pkt  = 0;
  int         exp_drop = 0;

  logic [7:0] acc_q[$];
  logic       acc_last[$];
  int         acc_cyc[$];
  int         ren_cnt;
  int         first_ren_cyc;
  int         first_valid_cyc;
  bit         busy_chk = 1'b0;

  bit         hold_v = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  logic       s_valid, s_last, s_busy, s_ren;
  logic [7:0] s_data;
  logic [15:0] s_pkt, s_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write one byte into the FIFO and advance the packet-level reference.
  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
    if (p_rem == 0) begin
      if (b == 8'h00) exp_drop++;
      else            p_rem = int'(b);
    end else begin
      exp_q.push_back({(p_rem == 1), b});
      p_rem--;
    end
  endtask

  task automatic clear_stats();
    acc_q.delete();
    acc_last.delete();
    acc_cyc.delete();
    ren_cnt         = 0;
    first_ren_cyc   = -1;
    first_valid_cyc = -1;
  endtask

  // Per-cycle comparison against the reference, at the falling edge.
  task automatic compare_cycle();
    logic [8:0] e;
    check("ren_on_empty", 32'(bus.fifo_ren & bus.fifo_empty), 32'd0);
    check("pkt_cnt", 32'(bus.pkt_cnt), 32'(exp_pkt));
    check("drop_cnt_bound", 32'(bus.drop_cnt <= 16'(exp_drop)), 32'd1);
    if (hold_v) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(hold_data));
      check("hold_last", 32'(bus.out_last), 32'(hold_last));
    end
    if (busy_chk && (p_rem != 0 || exp_q.size() > 0)) begin
      check("busy_mid_packet", 32'(bus.busy), 32'd1);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got %0h expected no beat (cycle %0d)", bus.out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(bus.out_data), 32'(e[7:0]));
        check("beat_last", 32'(bus.out_last), 32'(e[8]));
        if (e[8]) exp_pkt++;
      end
      acc_q.push_back(bus.out_data);
      acc_last.push_back(bus.out_last);
      acc_cyc.push_back(cyc);
    end
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    hold_v    = bus.out_valid & ~bus.out_ready;
    hold_data = bus.out_data;
    hold_last = bus.out_last;
  endtask

  // One clock: sample and compare at negedge, then model the FIFO read port.
  task automatic tick();
    logic ren_q;
    @(negedge clk);
    s_valid = bus.out_valid; s_data = bus.out_data; s_last = bus.out_last;
    s_pkt = bus.pkt_cnt; s_drop = bus.drop_cnt; s_busy = bus.busy; s_ren = bus.fifo_ren;
    if (rst) hold_v = 1'b0;
    else     compare_cycle();
    ren_q = bus.fifo_ren;
    if (ren_q) begin
      ren_cnt++;
      if (first_ren_cyc < 0) first_ren_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (ren_q && fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", 32'(s_valid), 32'd0);
    check("rst_out_last", 32'(s_last), 32'd0);
    check("rst_out_data", 32'(s_data), 32'd0);
    check("rst_pkt_cnt", 32'(s_pkt), 32'd0);
    check("rst_drop_cnt", 32'(s_drop), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_ren", 32'(s_ren), 32'd0);
  endtask

  // Reset DUT and FIFO together; the reference forgets everything.
  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    p_rem = 0; exp_pkt = 0; exp_drop = 0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = 8'h00;
    tick();
    check_reset_values();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic run_until_idle(input string name, input int bound);
    bit idle = 1'b0;
    for (int i = 0; i < bound && !idle; i++) begin
      tick();
      idle = (exp_q.size() == 0) && (fifo_q.size() == 0) && !s_busy && !s_valid;
    end
    check({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = 8'h00;
    bus.out_ready  = 1'b0;

    // Single 3-byte packet.
    do_reset();
    bus.out_ready = 1'b1;
    push_byte(8'h03); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    run_until_idle("t1", 40);
    check("t1_n", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      check("t1_b0", 32'(acc_q[0]), 32'hAA);
      check("t1_b1", 32'(acc_q[1]), 32'hBB);
      check("t1_b2", 32'(acc_q[2]), 32'hCC);
      check("t1_last", 32'({acc_last[0], acc_last[1], acc_last[2]}), 32'b001);
    end
    // Header read in cycle N is captured at the following edge; out_valid
    // rises three edges after that capture, i.e. it is first seen in cycle N+4.
    check("t1_hdr_to_valid", 32'(first_valid_cyc - first_ren_cyc), 32'd4);
    check("t1_pkt_cnt", 32'(s_pkt), 32'd1);

    // Two back-to-back packets.
    do_reset();
    bus.out_ready = 1'b1;
    push_byte(8'h02); push_byte(8'h11); push_byte(8'h22);
    push_byte(8'h01); push_byte(8'h33);
    run_until_idle("t2", 40);
    check("t2_n", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      check("t2_b0", 32'(acc_q[0]), 32'h11);
      check("t2_b1", 32'(acc_q[1]), 32'h22);
      check("t2_b2", 32'(acc_q[2]), 32'h33);
      check("t2_last", 32'({acc_last[0], acc_last[1], acc_last[2]}), 32'b011);
      check("t2_in_pkt_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      check("t2_bubble", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    check("t2_pkt_cnt", 32'(s_pkt), 32'd2);

    // Zero-length header is dropped.
    do_reset();
    bus.out_ready = 1'b1;
    push_byte(8'h00); push_byte(8'h01); push_byte(8'h5A);
    run_until_idle("t3", 40);
    check("t3_n", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() == 1) begin
      check("t3_b0", 32'(acc_q[0]), 32'h5A);
      check("t3_last", 32'(acc_last[0]), 32'd1);
    end
    check("t3_drop_cnt", 32'(s_drop), 32'd1);
    check("t3_drop_model", 32'(s_drop), 32'(exp_drop));
    check("t3_pkt_cnt", 32'(s_pkt), 32'd1);

    // Back-pressure: only two payload reads may be outstanding.
    do_reset();
    bus.out_ready = 1'b0;
    push_byte(8'h05);
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    for (int i = 0; i < 6; i++) tick();
    check("t4_ren_total", 32'(ren_cnt), 32'd3);
    check("t4_ren_low", 32'(s_ren), 32'd0);
    check("t4_valid_held", 32'(s_valid), 32'd1);
    check("t4_data_held", 32'(s_data), 32'h01);
    bus.out_ready = 1'b1;
    run_until_idle("t4", 40);
    check("t4_n", 32'(acc_q.size()), 32'd5);
    for (int i = 0; i < acc_q.size(); i++) check("t4_order", 32'(acc_q[i]), 32'(i + 1));
    check("t4_pkt_cnt", 32'(s_pkt), 32'd1);

    // FIFO runs dry mid-packet.
    do_reset();
    bus.out_ready = 1'b1;
    push_byte(8'h04); push_byte(8'hA1); push_byte(8'hA2);
    tick();
    busy_chk = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t5_stall_busy", 32'(s_busy), 32'd1);
    check("t5_partial_n", 32'(acc_q.size()), 32'd2);
    push_byte(8'hA3); push_byte(8'hA4);
    run_until_idle("t5", 40);
    busy_chk = 1'b0;
    check("t5_n", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      check("t5_b2", 32'(acc_q[2]), 32'hA3);
      check("t5_b3", 32'(acc_q[3]), 32'hA4);
      check("t5_last", 32'({acc_last[0], acc_last[1], acc_last[2], acc_last[3]}), 32'b0001);
    end
    check("t5_pkt_cnt", 32'(s_pkt), 32'd1);

    // Reset in the middle of a packet, then a fresh packet.
    do_reset();
    bus.out_ready = 1'b1;
    push_byte(8'h04); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    for (int i = 0; i < 40 && acc_q.size() < 2; i++) tick();
    check("t6_two_emitted", 32'(acc_q.size()), 32'd2);
    do_reset();
    push_byte(8'h01); push_byte(8'h77);
    run_until_idle("t6", 40);
    check("t6_n", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() == 1) begin
      check("t6_b0", 32'(acc_q[0]), 32'h77);
      check("t6_last", 32'(acc_last[0]), 32'd1);
    end
    check("t6_pkt_cnt", 32'(s_pkt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
